sdram_burst_responder: RTL and testbench

SDRAM_BURST_RESPONDER -- requirements
Module: sdram_burst_responder

---
 rtl/sdram_burst_responder.sv | 155 +++++++++++++++
 tb/tb_sdram_burst_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_responder.sv
// SDRAM-style burst responder: serves write/read bursts from an on-chip
// word store with registered handshakes and one-cycle finish pulses.
module sdram_burst_responder #(
   parameter int ADDR_WIDTH     = 24,
   parameter int MEM_DATA_WIDTH = 16,
   parameter int BURST_WIDTH    = 8,
   parameter int MEM_DEPTH_LOG2 = 10
) (
   input  logic                      i_sys_clk,
   input  logic                      i_sys_rst_n,
   input  logic                      i_rd_burst_req,
   input  logic [BURST_WIDTH-1:0]    i_rd_burst_len,
   input  logic [ADDR_WIDTH-1:0]     i_rd_burst_addr,
   output logic                      o_rd_burst_data_valid,
   output logic [MEM_DATA_WIDTH-1:0] o_rd_burst_data,
   output logic                      o_rd_burst_finish,
   input  logic                      i_wr_burst_req,
   input  logic [BURST_WIDTH-1:0]    i_wr_burst_len,
   input  logic [ADDR_WIDTH-1:0]     i_wr_burst_addr,
   output logic                      o_wr_burst_data_req,
   input  logic [MEM_DATA_WIDTH-1:0] i_wr_burst_data,
   output logic                      o_wr_burst_finish,
   output logic                      o_busy
);

   localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_BURST = 3'd1;
   localparam logic [2:0] WR_TAIL  = 3'd2;
   localparam logic [2:0] WR_END   = 3'd3;
   localparam logic [2:0] RD_BURST = 3'd4;
   localparam logic [2:0] RD_END   = 3'd5;

   logic [2:0]                state;
   logic [BURST_WIDTH-1:0]    len_q;
   logic [BURST_WIDTH-1:0]    cnt;
   logic [MEM_DEPTH_LOG2-1:0] wr_ptr;
   logic [MEM_DEPTH_LOG2-1:0] rd_ptr;
   logic                      wr_pend;
   logic                      rd_issue;
   logic                      rst_meta;
   logic                      rst_sync_n;
   logic                      unused_addr_bits;

   logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

   // Only the low address bits index the store; the rest wrap away.
   assign unused_addr_bits = ^{i_wr_burst_addr, i_rd_burst_addr};

   // Reset asserts at once but releases on a clock edge.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         rst_meta   <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta   <= 1'b1;
         rst_sync_n <= rst_meta;
      end
   end

   assign rd_issue = (state == RD_BURST) && (cnt != len_q);

   // Store is never reset so contents survive a reset pulse.
   always_ff @(posedge i_sys_clk) begin
      if (wr_pend) begin
         mem[wr_ptr] <= i_wr_burst_data;
      end
   end

   always_ff @(posedge i_sys_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state                 <= IDLE;
         len_q                 <= '0;
         cnt                   <= '0;
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         wr_pend               <= 1'b0;
         o_wr_burst_data_req   <= 1'b0;
         o_wr_burst_finish     <= 1'b0;
         o_rd_burst_data_valid <= 1'b0;
         o_rd_burst_data       <= '0;
         o_rd_burst_finish     <= 1'b0;
         o_busy                <= 1'b0;
      end else begin
         o_wr_burst_finish     <= 1'b0;
         o_rd_burst_finish     <= 1'b0;
         // Data arrives one clock after each request.
         wr_pend               <= o_wr_burst_data_req;
         o_rd_burst_data_valid <= rd_issue;
         if (wr_pend) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_issue) begin
            o_rd_burst_data <= mem[rd_ptr];
            rd_ptr          <= rd_ptr + 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (i_wr_burst_req) begin
                  len_q  <= i_wr_burst_len;
                  cnt    <= '0;
                  wr_ptr <= i_wr_burst_addr[MEM_DEPTH_LOG2-1:0];
                  o_busy <= 1'b1;
                  if (i_wr_burst_len == '0) begin
                     state <= WR_TAIL;
                  end else begin
                     state               <= WR_BURST;
                     o_wr_burst_data_req <= 1'b1;
                  end
               end else if (i_rd_burst_req) begin
                  len_q  <= i_rd_burst_len;
                  cnt    <= '0;
                  rd_ptr <= i_rd_burst_addr[MEM_DEPTH_LOG2-1:0];
                  o_busy <= 1'b1;
                  state  <= RD_BURST;
               end
            end
            WR_BURST: begin
               cnt <= cnt + 1'b1;
               if (cnt == len_q - 1'b1) begin
                  o_wr_burst_data_req <= 1'b0;
                  state               <= WR_TAIL;
               end
            end
            WR_TAIL: begin
               o_wr_burst_finish <= 1'b1;
               state             <= WR_END;
            end
            WR_END: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            RD_BURST: begin
               // Extra cycle past the last issue drains the read latency.
               if (cnt == len_q) begin
                  o_rd_burst_finish <= 1'b1;
                  state             <= RD_END;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RD_END: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Randomized bench for sdram_burst_responder against a
// transaction-level timing and memory model.
module tb_sdram_burst_responder;

   localparam int AW    = 24;
   localparam int DW    = 16;
   localparam int BW    = 8;
   localparam int ML    = 10;
   localparam int DEPTH = 1 << ML;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_req = 1'b0;
   logic [BW-1:0] rd_len = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_vld;
   logic [DW-1:0] rd_data;
   logic          rd_fin;
   logic          wr_req = 1'b0;
   logic [BW-1:0] wr_len = '0;
   logic [AW-1:0] wr_addr = '0;
   logic          wr_dreq;
   logic [DW-1:0] wr_data = '0;
   logic          wr_fin;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   bit            ref_ok  [DEPTH];
   logic [DW-1:0] wq [$];

   always #5 clk = ~clk;

   sdram_burst_responder #(
      .ADDR_WIDTH(AW),
      .MEM_DATA_WIDTH(DW),
      .BURST_WIDTH(BW),
      .MEM_DEPTH_LOG2(ML)
   ) dut (
      .i_sys_clk(clk),
      .i_sys_rst_n(rst_n),
      .i_rd_burst_req(rd_req),
      .i_rd_burst_len(rd_len),
      .i_rd_burst_addr(rd_addr),
      .o_rd_burst_data_valid(rd_vld),
      .o_rd_burst_data(rd_data),
      .o_rd_burst_finish(rd_fin),
      .i_wr_burst_req(wr_req),
      .i_wr_burst_len(wr_len),
      .i_wr_burst_addr(wr_addr),
      .o_wr_burst_data_req(wr_dreq),
      .i_wr_burst_data(wr_data),
      .o_wr_burst_finish(wr_fin),
      .o_busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One burst from the IDLE cycle T to the finish cycle T+len+2.
   task automatic burst(input bit wr, input int unsigned addr,
                        input int len, input bit hold, input bit co_rd);
      int            base;
      int            idx;
      bit            dreq_prev;
      bit            have_last;
      logic [DW-1:0] last;
      int            a;
      bit            exp_v;
      base      = int'(addr % DEPTH);
      idx       = 0;
      dreq_prev = 0;
      have_last = 0;
      last      = '0;
      @(negedge clk);
      chk("idle_before", busy, 0);
      if (wr) begin
         wr_req  = 1'b1;
         wr_addr = AW'(addr);
         wr_len  = BW'(len);
         if (co_rd) begin
            rd_req  = 1'b1;
            rd_addr = AW'(addr);
            rd_len  = BW'(len);
         end
      end else begin
         rd_req  = 1'b1;
         rd_addr = AW'(addr);
         rd_len  = BW'(len);
      end
      for (int k = 1; k <= len + 2; k++) begin
         @(negedge clk);
         chk("busy", busy, 1);
         if (wr) begin
            if (dreq_prev && idx < wq.size()) begin
               wr_data = wq[idx];
               idx++;
            end else begin
               wr_data = DW'($urandom);
            end
            dreq_prev = wr_dreq;
            chk("wr_dreq", wr_dreq, 32'(k <= len));
            chk("wr_fin", wr_fin, 32'(k == len + 2));
            chk("rd_vld_in_wr", rd_vld, 0);
            chk("rd_fin_in_wr", rd_fin, 0);
            if (k == 1) begin
               wr_addr = AW'($urandom);
               wr_len  = BW'($urandom);
            end
            if (k == len + 2 && !hold) wr_req = 1'b0;
         end else begin
            exp_v = (k >= 2) && (k <= len + 1);
            chk("rd_vld", rd_vld, 32'(exp_v));
            if (exp_v) begin
               a = (base + k - 2) % DEPTH;
               if (ref_ok[a]) chk("rd_data", rd_data, ref_mem[a]);
               last      = ref_mem[a];
               have_last = ref_ok[a];
            end else if (have_last) begin
               chk("rd_hold", rd_data, last);
            end
            chk("rd_fin", rd_fin, 32'(k == len + 2));
            chk("wr_dreq_in_rd", wr_dreq, 0);
            chk("wr_fin_in_rd", wr_fin, 0);
            if (k == 1) begin
               rd_addr = AW'($urandom);
               rd_len  = BW'($urandom);
            end
            if (k == len + 2 && !hold) rd_req = 1'b0;
         end
      end
      if (wr) begin
         for (int j = 0; j < len; j++) begin
            ref_mem[(base + j) % DEPTH] = wq[j];
            ref_ok[(base + j) % DEPTH]  = 1'b1;
         end
      end
   endtask

   initial begin
      int unsigned ra;
      int          rl;
      int          ro;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_wr_dreq", wr_dreq, 0);
      chk("rst_wr_fin", wr_fin, 0);
      chk("rst_rd_vld", rd_vld, 0);
      chk("rst_rd_fin", rd_fin, 0);
      chk("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      wq = {16'd1, 16'd2, 16'd3, 16'd4};
      burst(1, 32'h10, 4, 0, 0);
      burst(0, 32'h10, 4, 0, 0);

      wq = {};
      burst(1, 32'h10, 0, 0, 0);
      burst(0, 32'h10, 0, 0, 0);
      burst(0, 32'h10, 4, 0, 0);

      wq = {};
      for (int j = 1; j <= 8; j++) wq.push_back(DW'(j));
      burst(1, 1020, 8, 0, 0);
      burst(0, 0, 4, 0, 0);
      burst(0, 1018, 8, 0, 0);

      wq = {};
      for (int j = 0; j < 6; j++) wq.push_back(DW'($urandom));
      burst(1, 32'h40, 6, 0, 1);
      burst(0, 32'h40, 6, 0, 0);

      for (int b = 0; b < 4; b++) begin
         wq = {};
         for (int j = 0; j < 128; j++) wq.push_back(DW'(b * 128 + j + 1));
         burst(1, b * 128, 128, b < 3, 0);
      end
      for (int b = 0; b < 4; b++) burst(0, b * 128, 128, b < 3, 0);

      @(negedge clk);
      rd_req  = 1'b1;
      rd_addr = AW'(32'h10);
      rd_len  = BW'(16);
      repeat (3) @(negedge clk);
      chk("pre_rst_vld", rd_vld, 1);
      rst_n  = 1'b0;
      rd_req = 1'b0;
      #1;
      chk("mid_rst_vld", rd_vld, 0);
      chk("mid_rst_fin", rd_fin, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", rd_data, 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 4) rst_n = 1'b1;
         chk("no_fin_after_rst", rd_fin, 0);
      end
      burst(0, 32'h10, 2, 0, 0);

      for (int it = 0; it < 12; it++) begin
         ra = $urandom;
         rl = $urandom_range(0, 24);
         wq = {};
         for (int j = 0; j < rl; j++) wq.push_back(DW'($urandom));
         burst(1, ra, rl, 0, 0);
         ro = $urandom_range(0, 4);
         burst(0, ra + ro, $urandom_range(0, 24), 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
